spi_eeprom_responder: RTL

- SPI mode-0 slave modelling a 128-byte 25AA010A-class serial EEPROM: command decode, status register, page-buffered writes, sequential reads.
- Responds to the SPI bit-bang tasks and to the SPI master behind the Wishbone top, giving a synthesizable, clock-domain-clean memory target for system simulation and FPGA loopback.
- SCK, CS_N and SI are oversampled in the CLK_I domain; no logic is clocked by SCK.

---
 rtl/spi_eeprom_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 slave modelling a 128-byte serial EEPROM (25AA010A-class).
// All SPI pins are oversampled in the CLK_I domain; nothing is clocked by SCK.
module spi_eeprom_responder #(
    parameter int ADDR_W       = 7,
    parameter int PAGE_W       = 4,
    parameter int WRITE_CYCLES = 1000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic CLK_I,
    input  logic RST_N_I,
    input  logic SCK_I,
    input  logic CS_N_I,
    input  logic SI_I,
    output logic SO_O,
    output logic SO_OE_O,
    output logic WIP_O
);

    localparam int          DEPTH = 1 << ADDR_W;
    localparam int unsigned PAGE  = 1 << PAGE_W;
    localparam int          TW    = $clog2(WRITE_CYCLES + 1);

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_STATUS = 3'd4;
    localparam logic [2:0] S_WR     = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, si_sync;
    logic                   sck_s, cs_s, si_s, sck_d, cs_d;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall, byte_done;
    logic [2:0]             state, state_nxt, bit_cnt;
    logic [6:0]             shift_in;
    logic [7:0]             rx_byte, cmd, tx_sr, status;
    logic [ADDR_W-1:0]      ptr, rx_addr;
    logic [TW-1:0]          timer;
    logic                   wel, wip, commit;
    logic [PAGE-1:0]        mask;
    logic [7:0]             mem     [DEPTH];
    logic [7:0]             pagebuf [PAGE];

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign si_s      = si_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d & ~cs_s;
    assign sck_fall  = ~sck_s & sck_d & ~cs_s;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {shift_in, si_s};
    assign rx_addr   = rx_byte[ADDR_W-1:0];
    assign wip       = (timer != '0);
    assign status    = {6'b0, wel, wip};
    assign WIP_O     = wip;
    // A partial trailing byte (bit_cnt != 0) or an empty buffer aborts the write.
    assign commit    = cs_rise && (state == S_WR) && (bit_cnt == 3'd0) && wel && !wip && (|mask);

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            si_sync  <= '0;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK_I};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS_N_I};
            si_sync  <= {si_sync[SYNC_STAGES-2:0], SI_I};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (!cs_s) state_nxt = S_CMD;
                S_CMD: if (byte_done) begin
                    if (rx_byte == OP_RDSR)                              state_nxt = S_STATUS;
                    else if (!wip && (rx_byte == OP_READ || rx_byte == OP_WRITE)) state_nxt = S_ADDR;
                    else                                                 state_nxt = S_IGNORE;
                end
                S_ADDR: if (byte_done) state_nxt = (cmd == OP_READ) ? S_RD : S_WR;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shift_in <= '0;
            cmd      <= '0;
            ptr      <= '0;
            tx_sr    <= '0;
            SO_O     <= 1'b0;
            SO_OE_O  <= 1'b0;
            wel      <= 1'b0;
            timer    <= '0;
            mask     <= '0;
        end else begin
            state <= state_nxt;
            if (cs_fall)       bit_cnt <= '0;
            else if (sck_rise) bit_cnt <= bit_cnt + 3'd1;
            if (sck_rise) shift_in <= rx_byte[6:0];

            if (byte_done) begin
                case (state)
                    S_CMD: begin
                        // Opcodes arriving while busy are neutralised so IGNORE has no effect.
                        cmd <= (wip && rx_byte != OP_RDSR) ? 8'h00 : rx_byte;
                        if (rx_byte == OP_RDSR) tx_sr <= status;
                    end
                    S_ADDR: begin
                        if (cmd == OP_READ) begin
                            tx_sr <= mem[rx_addr];
                            ptr   <= rx_addr + ADDR_W'(1);
                        end else begin
                            ptr   <= rx_addr;
                        end
                    end
                    S_RD: begin
                        tx_sr <= mem[ptr];
                        ptr   <= ptr + ADDR_W'(1);
                    end
                    S_STATUS: tx_sr <= status;
                    S_WR: begin
                        mask[ptr[PAGE_W-1:0]] <= 1'b1;
                        ptr[PAGE_W-1:0]       <= ptr[PAGE_W-1:0] + PAGE_W'(1);
                    end
                    default: ;
                endcase
            end else if (sck_fall && (state == S_RD || state == S_STATUS)) begin
                SO_O  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
            end

            SO_OE_O <= (state_nxt == S_RD) || (state_nxt == S_STATUS);
            if (!(state_nxt == S_RD || state_nxt == S_STATUS)) SO_O <= 1'b0;

            if (commit)           timer <= TW'(WRITE_CYCLES);
            else if (timer != '0) timer <= timer - TW'(1);

            if (commit) wel <= 1'b0;
            else if (cs_rise && state == S_IGNORE) begin
                if (cmd == OP_WREN)      wel <= 1'b1;
                else if (cmd == OP_WRDI) wel <= 1'b0;
            end

            if (cs_fall || cs_rise) mask <= '0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (state == S_WR && byte_done) pagebuf[ptr[PAGE_W-1:0]] <= rx_byte;
        if (commit) begin
            for (int unsigned i = 0; i < PAGE; i++) begin
                if (mask[i]) mem[{ptr[ADDR_W-1:PAGE_W], PAGE_W'(i)}] <= pagebuf[i];
            end
        end
    end

endmodule
